// File: rtl/match_scan_ctrl_pkg.sv
// Shared Stage 1 definitions: dictionary geometry, scan FSM states and the
// candidate (word, byte) record used by the match scanner.
package stage1_pkg;

   localparam int DICT_WORDS     = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int DICT_BYTES     = DICT_WORDS * BYTES_PER_WORD;

   typedef enum logic {
      IDLE,
      SCAN
   } scan_state_t;

   typedef struct packed {
      logic [$clog2(DICT_WORDS)-1:0]     word_idx;
      logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx;
   } match_cand_t;

   // One-hot mask selecting the compare-vector bit that a candidate names.
   function automatic logic [DICT_BYTES-1:0] cand_mask(input match_cand_t cand);
      logic [DICT_BYTES-1:0] one;
      one = {{(DICT_BYTES-1){1'b0}}, 1'b1};
      return one << {cand.word_idx, cand.byte_idx};
   endfunction

endpackage

// File: rtl/match_scan_ctrl_if.sv
// Handshake bundle for match_scan_ctrl: compare-vector input stream and the
// candidate output stream. The slave modport is the scanner itself.
// Optional macro MATCH_SCAN_CNT_EN adds the out_cnt and truncated signals.
interface match_scan_if;
   import stage1_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DICT_BYTES-1:0] in_vec;
   logic                  out_valid;
   logic                  out_ready;
   logic [3:0]            out_word_idx;
   logic [1:0]            out_byte_idx;
   logic                  out_last;
   logic                  out_none;
   logic                  busy;
`ifdef MATCH_SCAN_CNT_EN
   logic [5:0]            out_cnt;
   logic                  truncated;
`endif

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_word_idx, out_byte_idx, out_last, out_none, busy
`ifdef MATCH_SCAN_CNT_EN
      , output out_cnt, truncated
`endif
   );

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_word_idx, out_byte_idx, out_last, out_none, busy
`ifdef MATCH_SCAN_CNT_EN
      , input out_cnt, truncated
`endif
   );

endinterface

// File: rtl/match_scan_ctrl_priority_encoder.sv
// 64-input priority encoder: reports the lowest set bit of the compare
// vector as a (word, byte) pair. An all-zero vector reports index 0; the
// caller masks that case with its own empty flag.
module priority_encoder_64
   import stage1_pkg::*;
(
   input  logic [DICT_BYTES-1:0] vec,
   output match_cand_t           cand
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      cand = '0;
      for (int i = DICT_BYTES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            cand = match_cand_t'(6'(i));
         end
      end
   end

endmodule

// File: rtl/match_scan_ctrl.sv
// match_scan_ctrl: holds one dictionary compare vector and emits each set bit
// as a (word, byte) candidate, lowest first, one per accepted beat, stopping
// when the vector empties or MAX_CAND candidates have been sent.
// Optional macro MATCH_SCAN_CNT_EN exposes the candidate ordinal (out_cnt)
// and a flag (truncated) telling that the candidate limit cut the scan short.
module match_scan_ctrl
   import stage1_pkg::*;
#(
   parameter int MAX_CAND = 8
)(
   input  logic         clk,
   input  logic         reset,
   match_scan_if.slave  bus
);

   localparam logic [5:0] LAST_CNT = 6'(MAX_CAND - 1);

   scan_state_t           state_q;
   scan_state_t           state_d;
   logic [DICT_BYTES-1:0] vec_q;
   logic [DICT_BYTES-1:0] vec_d;
   logic [5:0]            cnt_q;
   logic [5:0]            cnt_d;
   match_cand_t           cand;
   logic [DICT_BYTES-1:0] vec_cleared;
   logic                  vec_empty;
   logic                  vec_single;
   logic                  beat_last;
   logic                  scanning;

   priority_encoder_64 u_enc (
      .vec  (vec_q),
      .cand (cand)
   );

   // Remove the current candidate from the held vector and classify the beat.
   always_comb begin
      vec_cleared = vec_q & ~cand_mask(cand);
      vec_empty   = (vec_q == '0);
      vec_single  = !vec_empty && ((vec_q & (vec_q - 64'd1)) == '0);
      beat_last   = vec_empty || vec_single || (cnt_q == LAST_CNT);
   end

   // Next-state logic: latch a vector in IDLE, retire one candidate per accepted beat in SCAN.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               vec_d   = bus.in_vec;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (bus.out_ready) begin
               vec_d = vec_cleared;
               cnt_d = cnt_q + 6'd1;
               if (beat_last) begin
                  vec_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any partially emitted vector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Held compare vector and candidate ordinal.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec_q <= '0;
         cnt_q <= '0;
      end else begin
         vec_q <= vec_d;
         cnt_q <= cnt_d;
      end
   end

   assign scanning         = (state_q == SCAN);
   assign bus.in_ready     = (state_q == IDLE);
   assign bus.busy         = scanning;
   assign bus.out_valid    = scanning;
   assign bus.out_word_idx = scanning ? cand.word_idx : 4'd0;
   assign bus.out_byte_idx = scanning ? cand.byte_idx : 2'd0;
   assign bus.out_last     = scanning && beat_last;
   assign bus.out_none     = scanning && vec_empty;

`ifdef MATCH_SCAN_CNT_EN
   assign bus.out_cnt   = cnt_q;
   assign bus.truncated = scanning && beat_last && (vec_cleared != '0);
`endif

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Self-checking bench for match_scan_ctrl: a table of compare vectors with
// expected beat counts, a reference model that pushes expected beats into a
// scoreboard queue, and hand-written sequences for stalls, mid-scan reset and
// in_valid held during a scan. Works with or without MATCH_SCAN_CNT_EN.
module tb_match_scan_ctrl;

   localparam int MAX_CAND = 8;

   typedef struct packed {
      logic       valid;
      logic [3:0] widx;
      logic [1:0] bidx;
      logic       last;
      logic       none;
      logic [5:0] cnt;
      logic       trunc;
   } beat_t;

   typedef struct {
      logic [63:0] vec;
      int          exp_beats;
      int          ready_mode;
   } vec_rec_t;

   logic  clk;
   logic  reset;
   int    checks;
   int    errors;
   beat_t exp_q[$];

   match_scan_if bus ();

   match_scan_ctrl #(.MAX_CAND(MAX_CAND)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t sample_beat();
      beat_t s;
      s       = '0;
      s.valid = bus.out_valid;
      s.widx  = bus.out_word_idx;
      s.bidx  = bus.out_byte_idx;
      s.last  = bus.out_last;
      s.none  = bus.out_none;
`ifdef MATCH_SCAN_CNT_EN
      s.cnt   = bus.out_cnt;
      s.trunc = bus.truncated;
`endif
      return s;
   endfunction

   // Reference model: expected beats of one vector, lowest bit first, capped at MAX_CAND.
   function automatic void model_push(input logic [63:0] v);
      beat_t       b;
      logic [63:0] rem;
      int          cnt;
      bit          fin;
      rem = v;
      cnt = 0;
      fin = 1'b0;
      if (v == 64'd0) begin
         b       = '0;
         b.valid = 1'b1;
         b.last  = 1'b1;
         b.none  = 1'b1;
         exp_q.push_back(b);
         return;
      end
      for (int i = 0; i < 64 && !fin; i++) begin
         if (rem[i]) begin
            rem[i]  = 1'b0;
            b       = '0;
            b.valid = 1'b1;
            b.widx  = 4'(i / 4);
            b.bidx  = 2'(i % 4);
            b.last  = (rem == 64'd0) || (cnt == MAX_CAND - 1);
`ifdef MATCH_SCAN_CNT_EN
            b.cnt   = 6'(cnt);
            b.trunc = b.last && (rem != 64'd0);
`endif
            exp_q.push_back(b);
            cnt++;
            fin = b.last;
         end
      end
   endfunction

   // Offer a vector until accepted, then record its expected beats.
   task automatic apply_stimulus(input logic [63:0] v);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_vec   = v;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready got 0, want 1 for vec %h", v);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model_push(v);
   endtask

   // Consume beats until the expected last one; mode 0 always ready, 1 stalls
   // the first beat 3 cycles, 2 random ready. Stalled beats must match the queue head.
   task automatic drain(input int mode, output int beats);
      int    stall_left;
      int    cycles;
      bit    done;
      beat_t exp_b;
      beat_t act_b;
      stall_left = (mode == 1) ? 3 : 0;
      beats      = 0;
      cycles     = 0;
      done       = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (mode == 2) begin
            bus.out_ready = 1'($urandom_range(0, 1));
         end else if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else begin
            bus.out_ready = 1'b1;
         end
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expected beat, want one pending");
            done = 1'b1;
         end else begin
            exp_b = exp_q[0];
            act_b = sample_beat();
            check_output(bus.out_ready ? "beat" : "stall_hold", 32'(act_b), 32'(exp_b));
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               beats++;
               if (exp_b.last) done = 1'b1;
            end
         end
         cycles++;
         if (!done && cycles > 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats, want vector completion", beats);
            exp_q.delete();
            done = 1'b1;
         end
         @(posedge clk);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_output("idle_after_last", {30'd0, bus.in_ready, bus.busy}, 32'b10);
   endtask

   vec_rec_t table_v[8];
   int       nbeats;

   initial begin
      checks = 0;
      errors = 0;
      table_v[0] = '{64'h0000_0000_0000_0012, 2, 0};
      table_v[1] = '{64'h0000_0000_0000_0000, 1, 0};
      table_v[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8, 0};
      table_v[3] = '{64'h8000_0000_0000_0001, 2, 1};
      table_v[4] = '{64'hA5A5_0000_0000_0000, 8, 2};
      table_v[5] = '{64'h8000_0000_0000_0000, 1, 0};
      table_v[6] = '{64'h0000_0001_0000_0100, 2, 2};
      table_v[7] = '{64'h0000_0000_0000_03FF, 8, 2};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_outputs", 32'(sample_beat()), 32'd0);
      check_output("reset_ready_busy", {30'd0, bus.in_ready, bus.busy}, 32'b10);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(table_v[i].vec);
         drain(table_v[i].ready_mode, nbeats);
         check_output($sformatf("beat_count[%0d]", i), 32'(nbeats), 32'(table_v[i].exp_beats));
      end

      // Reset asserted while the second beat of 64'hF is on the bus.
      apply_stimulus(64'h0000_0000_0000_000F);
      @(negedge clk);
      bus.out_ready = 1'b1;
      check_output("rst_seq_beat0", 32'(sample_beat()), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_output("rst_seq_beat1", 32'(sample_beat()), 32'(exp_q[0]));
      reset = 1'b1;
      #1;
      check_output("midscan_reset_outputs", 32'(sample_beat()), 32'd0);
      check_output("midscan_reset_ready_busy", {30'd0, bus.in_ready, bus.busy}, 32'b10);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(64'h0000_0000_0000_0100);
      drain(0, nbeats);
      check_output("post_reset_beat_count", 32'(nbeats), 32'd1);

      // A second vector held on in_valid during a scan waits for IDLE.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_vec   = 64'h0000_0000_0000_0030;
      @(posedge clk);
      #1;
      bus.in_vec = 64'h0000_0000_0000_0001;
      model_push(64'h0000_0000_0000_0030);
      @(negedge clk);
      check_output("scan_blocks_input", {30'd0, bus.in_ready, bus.busy}, 32'b01);
      drain(0, nbeats);
      check_output("held_first_count", 32'(nbeats), 32'd2);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model_push(64'h0000_0000_0000_0001);
      drain(0, nbeats);
      check_output("held_second_count", 32'(nbeats), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
